// File: rtl/i2c_master_ctrl_if.sv
// rtl/i2c_master_ctrl_if.sv - host handshake and open-drain bus signals of the I2C master controller
interface i2c_master_ctrl_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       d_in;
  logic       d_out;
  logic       c_in;
  logic       c_out;

  modport master (
    input  start, rw, addr, wr_data, d_in, c_in,
    output rd_data, busy, done, ack_err, d_out, c_out
  );

  modport slave (
    output start, rw, addr, wr_data, d_in, c_in,
    input  rd_data, busy, done, ack_err, d_out, c_out
  );
endinterface

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-byte I2C master: START, address, one data byte, STOP
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  i2c_master_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WRITE_ACK,
    S_READ,
    S_READ_NACK,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [7:0] QLAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] qcnt_q, qcnt_d;       // cycles inside the current quarter
  logic [1:0] qidx_q, qidx_d;       // quarter index Q0..Q3 of the current bit slot
  logic [2:0] bit_q, bit_d;         // slot counter; START and STOP use bit 0 for their two slots
  logic [7:0] shift_q, shift_d;     // outgoing byte (ADDR/WRITE) or incoming byte (READ)
  logic [7:0] wbyte_q, wbyte_d;
  logic       rw_q, rw_d;
  logic       smp_q, smp_d;         // d_in captured at the end of Q2
  logic [7:0] rd_data_q, rd_data_d;
  logic       ack_err_q, ack_err_d;

  logic active;
  logic hold;
  logic q_end;
  logic slot_end;
  logic d_drv;
  logic c_drv;

  // Quarter timing strobes; a slave holding SCL low in Q2/Q3 freezes the counter
  always_comb begin
    active   = (state_q != S_IDLE) && (state_q != S_DONE);
    hold     = active && qidx_q[1] && !bus.c_in;
    q_end    = active && !hold && (qcnt_q == QLAST);
    slot_end = q_end && (qidx_q == 2'd3);
  end

  // Next-state, counters and datapath
  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    qidx_d    = qidx_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    wbyte_d   = wbyte_q;
    rw_d      = rw_q;
    smp_d     = smp_q;
    rd_data_d = rd_data_q;
    ack_err_d = ack_err_q;

    if (active && !hold) begin
      if (q_end) begin
        qcnt_d = '0;
        qidx_d = qidx_q + 2'd1;
      end else begin
        qcnt_d = qcnt_q + 8'd1;
      end
    end

    if (q_end && (qidx_q == 2'd2)) begin
      smp_d = bus.d_in;
    end

    case (state_q)
      S_IDLE: begin
        qcnt_d = '0;
        qidx_d = '0;
        bit_d  = '0;
        if (bus.start) begin
          state_d   = S_START;
          shift_d   = {bus.addr, bus.rw};
          wbyte_d   = bus.wr_data;
          rw_d      = bus.rw;
          ack_err_d = 1'b0;
        end
      end
      // first slot leaves the bus free, second slot carries the START edge
      S_START: begin
        if (slot_end) begin
          if (bit_q[0]) begin
            bit_d   = '0;
            state_d = S_ADDR;
          end else begin
            bit_d = 3'd1;
          end
        end
      end
      S_ADDR, S_WRITE: begin
        if (slot_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WRITE_ACK;
          end
        end
      end
      S_ADDR_ACK: begin
        if (slot_end) begin
          if (smp_q) begin
            ack_err_d = 1'b1;
            state_d   = S_STOP;
          end else if (rw_q) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
            shift_d = wbyte_q;
          end
        end
      end
      S_WRITE_ACK: begin
        if (slot_end) begin
          if (smp_q) begin
            ack_err_d = 1'b1;
          end
          state_d = S_STOP;
        end
      end
      // rd_data only changes once the whole byte is in, so it holds the previous read until then
      S_READ: begin
        if (slot_end) begin
          shift_d = {shift_q[6:0], smp_q};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rd_data_d = {shift_q[6:0], smp_q};
            state_d   = S_READ_NACK;
          end
        end
      end
      S_READ_NACK: begin
        if (slot_end) begin
          state_d = S_STOP;
        end
      end
      // first slot carries the STOP edge, second slot keeps the bus free before DONE
      S_STOP: begin
        if (slot_end) begin
          if (bit_q[0]) begin
            bit_d   = '0;
            state_d = S_DONE;
          end else begin
            bit_d = 3'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        qcnt_d  = '0;
        qidx_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Open-drain drive pattern from state, quarter and slot
  always_comb begin
    d_drv = 1'b1;
    c_drv = 1'b1;
    case (state_q)
      S_START: begin
        if (bit_q[0]) begin
          d_drv = !qidx_q[1];
        end
      end
      S_ADDR, S_WRITE: begin
        c_drv = qidx_q[1];
        d_drv = shift_q[7];
      end
      S_ADDR_ACK, S_WRITE_ACK, S_READ, S_READ_NACK: begin
        c_drv = qidx_q[1];
      end
      S_STOP: begin
        if (!bit_q[0]) begin
          c_drv = (qidx_q != 2'd0);
          d_drv = qidx_q[1];
        end
      end
      default: begin
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      qidx_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wbyte_q   <= '0;
      rw_q      <= 1'b0;
      smp_q     <= 1'b1;
      rd_data_q <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      qidx_q    <= qidx_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      wbyte_q   <= wbyte_d;
      rw_q      <= rw_d;
      smp_q     <= smp_d;
      rd_data_q <= rd_data_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign bus.d_out   = d_drv;
  assign bus.c_out   = c_drv;
  assign bus.busy    = active;
  assign bus.done    = (state_q == S_DONE);
  assign bus.rd_data = rd_data_q;
  assign bus.ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - randomized scoreboard bench for i2c_master_ctrl with a bus-level slave model
`timescale 1ns/1ps
module tb_i2c_master_ctrl;
  localparam int CLK_DIV = 4;
  localparam int SLOT    = 4 * CLK_DIV;

  logic clk = 1'b0;
  logic rst_n;
  logic s_sda   = 1'b1;
  logic stretch = 1'b0;
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_master_ctrl_if bus ();
  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  assign bus.d_in = bus.d_out & s_sda;
  assign bus.c_in = bus.c_out & ~stretch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Slave model: decodes START/STOP and SCL edges, ACKs on request, returns a read byte
  typedef enum int {P_IDLE, P_ADDR, P_WR, P_RD, P_END} ph_t;
  ph_t        ph = P_IDLE;
  int         bitn = 0;
  logic [7:0] sh = 8'h00;
  logic       nine = 1'b1;
  logic       psda = 1'b1, pscl = 1'b1, sv_sda, sv_scl;
  logic       sl_aack = 1'b1, sl_dack = 1'b1;
  logic [7:0] sl_rbyte = 8'h00;
  int         sl_addr = -1, sl_data = -1, sl_mnack = -1, sl_stops = 0;

  always @(negedge clk) begin
    sv_sda = bus.d_in;
    sv_scl = bus.c_out;
    if (!rst_n) begin
      ph = P_IDLE; bitn = 0; s_sda = 1'b1; psda = 1'b1; pscl = 1'b1;
    end else begin
      if (sv_scl && pscl && psda && !sv_sda) begin
        ph = P_ADDR; bitn = 0; sh = 8'h00; s_sda = 1'b1;
      end else if (sv_scl && pscl && !psda && sv_sda) begin
        ph = P_IDLE; s_sda = 1'b1; sl_stops++;
      end else if (sv_scl && !pscl) begin
        if (bitn < 8) sh = {sh[6:0], sv_sda};
        else nine = sv_sda;
        bitn++;
      end else if (!sv_scl && pscl) begin
        if (bitn == 8) begin
          case (ph)
            P_ADDR:  begin sl_addr = int'(sh); s_sda = !sl_aack; end
            P_WR:    begin sl_data = int'(sh); s_sda = !sl_dack; end
            default: s_sda = 1'b1;
          endcase
        end else if (bitn == 9) begin
          bitn  = 0;
          s_sda = 1'b1;
          case (ph)
            P_ADDR:  ph = nine ? P_END : (sh[0] ? P_RD : P_WR);
            P_RD:    begin sl_mnack = int'(nine); ph = P_END; end
            default: ph = P_END;
          endcase
          if (ph == P_RD) s_sda = sl_rbyte[7];
        end else if (ph == P_RD) begin
          s_sda = sl_rbyte[3'(7 - bitn)];
        end
      end
      psda = sv_sda;
      pscl = sv_scl;
    end
  end

  // Scoreboard
  typedef struct {
    int         t_acc;
    int         lat;
    logic       ack_err;
    logic [7:0] rd;
    int         addr_byte;
    int         data;
    bit         chk_data;
    bit         chk_mnack;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pushed = 0;
  int   n_done   = 0;
  logic [7:0] model_rd = 8'h00;

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("latency", cyc - mon_e.t_acc, mon_e.lat);
        check("ack_err", bus.ack_err, mon_e.ack_err);
        check("rd_data", bus.rd_data, mon_e.rd);
        check("addr_byte_on_bus", sl_addr, mon_e.addr_byte);
        if (mon_e.chk_data) check("wr_byte_on_bus", sl_data, mon_e.data);
        if (mon_e.chk_mnack) check("master_nack", sl_mnack, 1);
        check("stop_seen", sl_stops, 1);
      end
    end
  end

  task automatic run_txn(input logic rw_i, input logic [6:0] a, input logic [7:0] wd,
                         input logic [7:0] rb, input logic aack, input logic dack,
                         input bit do_stretch, input bit do_dbl, input int rst_at,
                         input bit start_in_done);
    exp_t e;
    int   lat;
    int   t_acc;
    bit   c_ok;
    bit   got_done;
    sl_aack = aack; sl_dack = dack; sl_rbyte = rb;
    sl_addr = -1; sl_data = -1; sl_mnack = -1; sl_stops = 0;
    lat = (aack ? 22 : 13) * SLOT + (do_stretch ? 50 : 0);
    @(negedge clk);
    bus.start = 1'b1; bus.rw = rw_i; bus.addr = a; bus.wr_data = wd;
    @(negedge clk);
    bus.start = 1'b0;
    t_acc = cyc;
    check("busy_after_start", bus.busy, 1);
    if (rst_at == 0) begin
      if (rw_i && aack) model_rd = rb;
      e.t_acc     = t_acc;
      e.lat       = lat;
      e.ack_err   = !aack || (!rw_i && !dack);
      e.rd        = model_rd;
      e.addr_byte = int'({a, rw_i});
      e.data      = int'(wd);
      e.chk_data  = !rw_i && aack;
      e.chk_mnack = rw_i && aack;
      exp_q.push_back(e);
      n_pushed++;
    end
    c_ok = 1'b1;
    got_done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      if (rst_at > 0 && cyc == t_acc + rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_d_out", bus.d_out, 1);
        check("rst_c_out", bus.c_out, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ack_err", bus.ack_err, 0);
        check("rst_rd_data", bus.rd_data, 0);
        model_rd = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      bus.start = do_dbl && (cyc == t_acc + 40);
      if (do_dbl && cyc == t_acc + 40) begin
        bus.rw = ~rw_i; bus.addr = ~a; bus.wr_data = ~wd;
      end
      stretch = do_stretch && (cyc >= t_acc + 88) && (cyc < t_acc + 138);
      if (stretch && !bus.c_out) c_ok = 1'b0;
      @(negedge clk);
    end
    stretch   = 1'b0;
    bus.start = 1'b0;
    if (rst_at == 0) begin
      check("done_seen", got_done, 1);
      if (do_stretch) check("c_out_held_in_stretch", c_ok, 1);
      if (start_in_done && got_done) begin
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_in_done_ignored", bus.busy, 0);
      end
      @(negedge clk);
      check("idle_after_done", bus.busy, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       r_rw, r_aack, r_dack, r_dbl;
    logic [6:0] r_a;
    logic [7:0] r_wd, r_rb;
    rst_n = 1'b1;
    bus.start = 1'b0; bus.rw = 1'b0; bus.addr = 7'h00; bus.wr_data = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    check("reset_d_out", bus.d_out, 1);
    check("reset_c_out", bus.c_out, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_ack_err", bus.ack_err, 0);
    check("reset_rd_data", bus.rd_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(1'b0, 7'h2A, 8'hC5, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    run_txn(1'b1, 7'h2A, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_txn(1'b0, 7'h2A, 8'hC5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_txn(1'b0, 7'h2A, 8'hC5, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    run_txn(1'b0, 7'h2A, 8'hC5, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 244, 1'b0);
    run_txn(1'b0, 7'h11, 8'h96, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_txn(1'b1, 7'h55, 8'h00, 8'hA7, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      r_rw   = 1'($urandom_range(0, 1));
      r_a    = 7'($urandom);
      r_wd   = 8'($urandom);
      r_rb   = 8'($urandom);
      r_aack = ($urandom_range(0, 3) != 0);
      r_dack = ($urandom_range(0, 3) != 0);
      r_dbl  = ($urandom_range(0, 3) == 0);
      run_txn(r_rw, r_a, r_wd, r_rb, r_aack, r_dack, 1'b0, r_dbl, 0, r_dbl);
    end

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("done_count", n_done, n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
